// File: rtl/conv_pkg.sv
// Shared types and geometry for the conv1 sequencer: FSM states, image and window
// dimensions, and the bus widths derived from them.
package conv_pkg;
    localparam int WIDTH       = 28;
    localparam int HEIGHT      = 28;
    localparam int DATA_BITS   = 8;
    localparam int FILTER_SIZE = 7;
    localparam int MAX_FILTERS = 8;
    localparam int TIMEOUT     = 4096;

    localparam int OUT_W        = WIDTH - FILTER_SIZE + 1;
    localparam int OUT_H        = HEIGHT - FILTER_SIZE + 1;
    localparam int WIN_PER_PASS = OUT_W * OUT_H;
    localparam int NUM_PIX      = WIDTH * HEIGHT;

    localparam int ADDR_W = $clog2(NUM_PIX);
    localparam int CFG_W  = $clog2(MAX_FILTERS + 1);
    localparam int FIDX_W = $clog2(MAX_FILTERS);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BUF, S_STREAM, S_DRAIN, S_NEXT, S_DONE
    } state_t;
endpackage

// File: rtl/conv1_sched_if.sv
// Bundle of every non-clock signal between conv1_sched and its neighbours
// (control, image RAM, conv1_buf, MAC engine), plus the FSM state for observation.
interface conv1_sched_if;
    import conv_pkg::*;

    logic                 start;
    logic                 abort;
    logic [CFG_W-1:0]     filter_cfg;
    logic                 img_rd_en;
    logic [ADDR_W-1:0]    img_addr;
    logic [DATA_BITS-1:0] img_rd_data;
    logic                 buf_ready;
    logic                 valid_in;
    logic [DATA_BITS-1:0] data_in;
    logic                 valid_out_buf;
    logic                 calc_ready;
    logic                 eng_ready;
    logic                 win_fire;
    logic [FIDX_W-1:0]    filter_idx;
    logic [ROW_W-1:0]     win_row;
    logic [COL_W-1:0]     win_col;
    logic                 busy;
    logic                 done;
    logic                 err;
    state_t               state_dbg;

    // Handshakes: a window moves on a cycle where valid_out_buf and calc_ready are both
    // high (win_fire); valid_out_buf must not wait on calc_ready. Pixels are pushed with
    // valid_in, which is throttled by buf_ready two cycles upstream, so one pixel may
    // still land after buf_ready drops.
    modport slave (
        input  start, abort, filter_cfg, img_rd_data, buf_ready, valid_out_buf, eng_ready,
        output img_rd_en, img_addr, valid_in, data_in, calc_ready, win_fire,
               filter_idx, win_row, win_col, busy, done, err, state_dbg
    );
    modport master (
        output start, abort, filter_cfg, img_rd_data, buf_ready, valid_out_buf, eng_ready,
        input  img_rd_en, img_addr, valid_in, data_in, calc_ready, win_fire,
               filter_idx, win_row, win_col, busy, done, err, state_dbg
    );
endinterface

// File: rtl/conv1_win_cnt.sv
// Raster-order window position counter for one pass; last_o marks the final window.
module conv1_win_cnt import conv_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(OUT_W - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);
endmodule

// File: rtl/conv1_sched.sv
// conv1 sequencer: replays the image from RAM into conv1_buf once per filter, gates and
// tags the resulting windows for the MAC engine, with a watchdog on stalled passes.
module conv1_sched import conv_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    conv1_sched_if.slave  bus
);
    localparam logic [ADDR_W:0] NPIX = (ADDR_W + 1)'(NUM_PIX);

    state_t               state_q, state_d;
    logic [ADDR_W:0]      addr_cnt_q;
    logic                 rd_pend_q, valid_in_q;
    logic [DATA_BITS-1:0] data_in_q;
    logic [FIDX_W-1:0]    pass_q;
    logic [CFG_W-1:0]     passes_q;
    logic [WDOG_W-1:0]    wdog_q;
    logic                 err_q;

    logic active, rd_en, calc_rdy, fire, win_last, wd_trip, pass_more, go_idle, accept_start;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    assign active       = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign rd_en        = (state_q == S_STREAM) && bus.buf_ready && (addr_cnt_q < NPIX);
    assign calc_rdy     = bus.eng_ready && active;
    assign fire         = bus.valid_out_buf && calc_rdy;
    assign wd_trip      = active && !valid_in_q && !fire && (wdog_q == WDOG_W'(TIMEOUT - 1));
    assign pass_more    = (CFG_W'(pass_q) + CFG_W'(1)) < passes_q;
    assign go_idle      = bus.abort || wd_trip || (state_q == S_DONE);
    assign accept_start = (state_q == S_IDLE) && bus.start && !bus.abort;

    conv1_win_cnt u_win_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (bus.abort || wd_trip || !active),
        .inc_i  (fire),
        .row_o  (row),
        .col_o  (col),
        .last_o (win_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort || wd_trip) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (bus.start) state_d = S_WAIT_BUF;
                S_WAIT_BUF: if (bus.buf_ready) state_d = S_STREAM;
                S_STREAM:   if (rd_en && (addr_cnt_q == NPIX - 1'b1)) state_d = S_DRAIN;
                S_DRAIN:    if (fire && win_last) state_d = S_NEXT;
                S_NEXT:     state_d = pass_more ? S_WAIT_BUF : S_DONE;
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.img_rd_en  = rd_en;
        bus.calc_ready = calc_rdy;
        bus.win_fire   = fire;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_DONE);
        bus.state_dbg  = state_q;
    end

    // Datapath: any exit to IDLE flushes the read pipeline and all counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            valid_in_q <= 1'b0;
            data_in_q  <= '0;
            pass_q     <= '0;
            passes_q   <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (go_idle) begin
                addr_cnt_q <= '0;
                rd_pend_q  <= 1'b0;
                valid_in_q <= 1'b0;
                pass_q     <= '0;
                wdog_q     <= '0;
            end else begin
                rd_pend_q  <= rd_en;
                valid_in_q <= rd_pend_q;
                if (rd_en) addr_cnt_q <= addr_cnt_q + 1'b1;
                if (state_q == S_NEXT) begin
                    addr_cnt_q <= '0;
                    if (pass_more) pass_q <= pass_q + 1'b1;
                end
                if (accept_start) begin
                    passes_q   <= (bus.filter_cfg == '0) ? CFG_W'(1) : bus.filter_cfg;
                    pass_q     <= '0;
                    addr_cnt_q <= '0;
                end
                wdog_q <= (active && !valid_in_q && !fire) ? wdog_q + 1'b1 : '0;
            end
            if (rd_pend_q) data_in_q <= bus.img_rd_data;
            if (wd_trip && !bus.abort) err_q <= 1'b1;
            else if (accept_start)     err_q <= 1'b0;
        end
    end

    assign bus.img_addr   = addr_cnt_q[ADDR_W-1:0];
    assign bus.valid_in   = valid_in_q;
    assign bus.data_in    = data_in_q;
    assign bus.filter_idx = pass_q;
    assign bus.win_row    = row;
    assign bus.win_col    = col;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched: RAM and conv1_buf models around the DUT, a reference of the
// expected pixel and window streams per run, and a monitor that consumes them.
module tb_conv1_sched;
  import conv_pkg::*;

  localparam int TAG_W = FIDX_W + ROW_W + COL_W;

  logic clk, rst;
  conv1_sched_if bus();

  conv1_sched dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference data
  logic [DATA_BITS-1:0] ram [NUM_PIX];
  logic [DATA_BITS-1:0] exp_px_q[$];
  logic [TAG_W-1:0]     exp_win_q[$];

  // Every pass replays the whole image in address order and yields every window in raster order.
  task automatic push_expect(input int cfg);
    int np;
    np = (cfg == 0) ? 1 : cfg;
    for (int f = 0; f < np; f++) begin
      for (int p = 0; p < NUM_PIX; p++) exp_px_q.push_back(ram[p]);
      for (int r = 0; r < OUT_H; r++)
        for (int c = 0; c < OUT_W; c++)
          exp_win_q.push_back({FIDX_W'(f), ROW_W'(r), COL_W'(c)});
    end
  endtask

  // environment: RAM with 1-cycle latency, conv1_buf window model, ready patterns
  int  eng_mode = 0;
  int  br_mode = 0;
  int  br_low_until = -1;
  bit  stuck_vob = 1'b0;
  int  px_cnt = 0;
  int  win_k = 0;
  bit  rd_pend = 1'b0;
  logic [ADDR_W-1:0] rd_pend_addr = '0;

  always @(negedge clk) begin
    if (rd_pend) bus.img_rd_data = ram[rd_pend_addr];
    case (eng_mode)
      0:       bus.eng_ready = 1'b1;
      1:       bus.eng_ready = (cyc % 3 == 0);
      default: bus.eng_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (cyc < br_low_until) bus.buf_ready = 1'b0;
    else if (br_mode == 0)  bus.buf_ready = 1'b1;
    else                    bus.buf_ready = ($urandom_range(0, 3) != 0);
    // a window exists once its bottom-right pixel has been delivered
    bus.valid_out_buf = !stuck_vob && (win_k < WIN_PER_PASS) &&
      (px_cnt > (win_k / OUT_W + FILTER_SIZE - 1) * WIDTH + (win_k % OUT_W) + FILTER_SIZE - 1);
    #1;
    rd_pend = bus.img_rd_en;
    rd_pend_addr = bus.img_addr;
    if (rst || !bus.busy) begin
      px_cnt = 0;
      win_k = 0;
    end else begin
      if (bus.valid_in) px_cnt++;
      if (bus.win_fire) begin
        win_k++;
        if (win_k == WIN_PER_PASS) begin
          px_cnt = 0;
          win_k = 0;
        end
      end
    end
  end

  // monitor / scoreboard
  int fires_seen = 0;
  int done_cnt = 0;
  int last_vin_cyc = 0;
  bit done_prev = 1'b0;
  bit br_h1 = 1'b0;
  bit br_h2 = 1'b0;
  logic [TAG_W-1:0] last_tag = '0;

  always @(negedge clk) begin
    logic [DATA_BITS-1:0] ep;
    logic [TAG_W-1:0] et, tag;
    #1;
    if (!rst) begin
      if (bus.valid_in) begin
        chk("inflight_after_buf_ready_low", br_h2, 1);
        if (exp_px_q.size() == 0) chk("pixel_unexpected", 1, 0);
        else begin
          ep = exp_px_q.pop_front();
          chk("pixel_data", bus.data_in, ep);
        end
        last_vin_cyc = cyc;
      end
      if (bus.win_fire) begin
        chk("fire_gate", bus.eng_ready && bus.valid_out_buf, 1);
        tag = {bus.filter_idx, bus.win_row, bus.win_col};
        if (exp_win_q.size() == 0) chk("window_unexpected", 1, 0);
        else begin
          et = exp_win_q.pop_front();
          chk("window_tag", tag, et);
        end
        last_tag = tag;
        fires_seen++;
      end
      if (bus.done) begin
        chk("done_width", done_prev, 0);
        chk("done_pixels_left", exp_px_q.size(), 0);
        chk("done_windows_left", exp_win_q.size(), 0);
        done_cnt++;
      end
    end
    done_prev = bus.done;
    br_h2 = br_h1;
    br_h1 = bus.buf_ready;
  end

  // driver tasks
  task automatic do_start(input int cfg, input bit expect_run);
    @(negedge clk);
    bus.filter_cfg = CFG_W'(cfg);
    bus.start = 1'b1;
    if (expect_run) push_expect(cfg);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk({name, "_done_count"}, done_cnt - d0, 1);
    repeat (2) @(negedge clk);
    #2;
    chk({name, "_busy_after"}, bus.busy, 0);
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < NUM_PIX; p++) ram[p] = DATA_BITS'(p % 256);
  endtask

  task automatic fill_rand();
    for (int p = 0; p < NUM_PIX; p++) ram[p] = DATA_BITS'($urandom_range(0, 255));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int d0, n, f0, err_cyc;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.filter_cfg = '0;
    fill_ramp();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_img_rd_en", bus.img_rd_en, 0);
    chk("rst_img_addr", bus.img_addr, 0);
    chk("rst_valid_in", bus.valid_in, 0);
    chk("rst_calc_ready", bus.calc_ready, 0);
    chk("rst_win_fire", bus.win_fire, 0);
    chk("rst_position", {bus.filter_idx, bus.win_row, bus.win_col}, 0);
    @(negedge clk);
    rst = 1'b0;

    // single pass, ramp image, everything ready
    do_start(1, 1);
    wait_done(3000, "ramp_pass");
    chk("ramp_last_window", last_tag, {FIDX_W'(0), ROW_W'(OUT_H - 1), COL_W'(OUT_W - 1)});

    // three passes, random image
    fill_rand();
    do_start(3, 1);
    wait_done(9000, "three_pass");
    chk("three_last_window", last_tag, {FIDX_W'(2), ROW_W'(OUT_H - 1), COL_W'(OUT_W - 1)});

    // engine ready one cycle in three, buf_ready dropped for 20 cycles mid-stream
    eng_mode = 1;
    do_start(2, 1);
    repeat (300) @(negedge clk);
    br_low_until = cyc + 20;
    wait_done(12000, "throttled");

    // cfg 0 acts as one pass; random readiness; a start while busy is ignored
    fill_rand();
    eng_mode = 2;
    br_mode = 1;
    do_start(0, 1);
    repeat (50) @(negedge clk);
    do_start(5, 0);
    wait_done(8000, "cfg_zero");

    // start and abort together while idle: abort wins
    d0 = done_cnt;
    @(negedge clk);
    bus.filter_cfg = CFG_W'(1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #2;
    chk("start_abort_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    chk("start_abort_no_done", done_cnt, d0);

    // abort around window 100 of the second pass
    eng_mode = 0;
    br_mode = 0;
    d0 = done_cnt;
    f0 = fires_seen;
    do_start(2, 1);
    n = 0;
    while (fires_seen < f0 + WIN_PER_PASS + 100 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_window", fires_seen >= f0 + WIN_PER_PASS + 100, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #2;
    chk("abort_busy", bus.busy, 0);
    chk("abort_img_rd_en", bus.img_rd_en, 0);
    chk("abort_valid_in", bus.valid_in, 0);
    chk("abort_calc_ready", bus.calc_ready, 0);
    chk("abort_filter_idx", bus.filter_idx, 0);
    exp_px_q.delete();
    exp_win_q.delete();
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    do_start(1, 1);
    wait_done(3000, "after_abort");

    // watchdog: conv1_buf never produces a window
    stuck_vob = 1'b1;
    d0 = done_cnt;
    do_start(1, 1);
    n = 0;
    err_cyc = 0;
    while (!bus.err && n < NUM_PIX + TIMEOUT + 200) begin
      @(negedge clk); #2;
      n++;
    end
    err_cyc = cyc;
    chk("timeout_err", bus.err, 1);
    chk("timeout_busy", bus.busy, 0);
    chk("timeout_latency", err_cyc - last_vin_cyc, TIMEOUT + 1);
    chk("timeout_no_done", done_cnt, d0);
    chk("timeout_pixels_left", exp_px_q.size(), 0);
    exp_win_q.delete();
    stuck_vob = 1'b0;
    do_start(1, 1);
    #2;
    chk("start_clears_err", bus.err, 0);
    wait_done(3000, "after_timeout");

    // asynchronous reset in the middle of a pass
    do_start(1, 1);
    repeat (200) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_img_rd_en", bus.img_rd_en, 0);
    chk("arst_valid_in", bus.valid_in, 0);
    chk("arst_calc_ready", bus.calc_ready, 0);
    chk("arst_position", {bus.filter_idx, bus.win_row, bus.win_col}, 0);
    exp_px_q.delete();
    exp_win_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_start(1, 1);
    wait_done(3000, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
